// File: rtl/counter_load_seq.sv
// counter_load_seq: queues counter reload requests and issues each one as a single-cycle
//   load pulse to the loadable counter, either immediately or aligned to the count wrap.
// Latency: an immediate entry pulses `load` one cycle after acceptance; pulses are >= 3 cycles apart.
// Backpressure: req_ready drops while the FIFO holds DEPTH entries or while flush is high.
// Ports: clk/rst (async, active-high); req_valid/req_ready/req_data/req_sync request port;
//   flush discards the queue; count_in is the counter's count; load/load_h drive the counter;
//   level is FIFO occupancy; busy = queue non-empty or sequencer not idle.
// Optional feature macro: COUNTER_LOAD_SEQ_SYNC_EN (wrap-aligned entries and the ARM state).
module counter_load_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_data,
  input  logic                   req_sync,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       count_in,
  output logic                   load,
  output logic [WIDTH-1:0]       load_h,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

`ifdef COUNTER_LOAD_SEQ_SYNC_EN
  localparam int EW = WIDTH + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, LOAD = 2'd2, GAP = 2'd3} state_t;
`else
  localparam int EW = WIDTH;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd2, GAP = 2'd3} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [EW-1:0]    entry_in;
  logic [EW-1:0]    head;
  logic [WIDTH-1:0] head_data;
  logic             empty;
  logic             push;
  logic             pop;
  logic [LW-1:0]    level_nxt;
  logic             load_nxt;
  logic [WIDTH-1:0] load_h_nxt;

`ifdef COUNTER_LOAD_SEQ_SYNC_EN
  logic head_sync;
  assign entry_in  = {req_sync, req_data};
  assign head_sync = head[WIDTH];
`else
  // Without wrap alignment the sync flag and the counter value have no consumer.
  logic unused_cfg;
  assign unused_cfg = ^{req_sync, count_in};
  assign entry_in   = req_data;
`endif

  assign head      = mem[rd_ptr];
  assign head_data = head[WIDTH-1:0];
  assign empty     = (level == '0);

  // Ready looks only at registered occupancy, so a pop in the same cycle never frees a full slot.
  assign req_ready = (level != FULL) && !flush;
  assign push      = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
`ifdef COUNTER_LOAD_SEQ_SYNC_EN
            state_nxt = head_sync ? ARM : LOAD;
`else
            state_nxt = LOAD;
`endif
          end
        end
`ifdef COUNTER_LOAD_SEQ_SYNC_EN
        ARM:     if (count_in == '1) state_nxt = LOAD;
`endif
        LOAD:    state_nxt = GAP;
        GAP:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: the only way into LOAD is by consuming the head entry, so a pop is
  // exactly a transition into LOAD from any other state.
  always_comb begin
    pop        = (state_nxt == LOAD) && (state != LOAD);
    load_nxt   = pop;
    load_h_nxt = pop ? head_data : load_h;
  end

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  // Registered outputs and FIFO pointers; load_h keeps the last issued value through flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      load   <= 1'b0;
      load_h <= '0;
      busy   <= 1'b0;
    end else begin
      level  <= level_nxt;
      load   <= load_nxt;
      load_h <= load_h_nxt;
      busy   <= (level_nxt != '0) || (state_nxt != IDLE);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

endmodule

// File: tb/tb_counter_load_seq.sv
// Testbench for counter_load_seq: directed scenarios plus randomized traffic, all checked
// against a timestamp-based reference model (queue of requests, earliest-issue cycle, arm time).
// Observed vector order: {load, load_h, level, busy, req_ready}.
module tb_counter_load_seq;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
`ifdef COUNTER_LOAD_SEQ_SYNC_EN
  localparam int SYNC_PULSE   = 5;
  localparam int SYNC_F_PULSE = 3;
`else
  localparam int SYNC_PULSE   = 2;
  localparam int SYNC_F_PULSE = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_data = '0;
  logic             req_sync = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             load;
  logic [WIDTH-1:0] load_h;
  logic [LW-1:0]    level;
  logic             busy;

  always #5 clk = ~clk;

  counter_load_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_sync(req_sync), .flush(flush), .count_in(count_in),
    .load(load), .load_h(load_h), .level(level), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [4:0] mq[$];          // {sync, data}
  int         cyc = 0;        // index of the last clock edge
  int         free_at = 1;    // first edge at which the sequencer may issue again
  int         arm_at = -1;    // edge at which the head sync entry started waiting, -1 if none
  logic       m_load = 1'b0;
  logic [3:0] m_load_h = 4'h0;
  logic       m_busy = 1'b0;

  logic [9:0] got;
  assign got = {load, load_h, level, busy, req_ready};

  function automatic logic [9:0] expv();
    logic [LW-1:0] lv;
    lv = LW'(mq.size());
    return {m_load, m_load_h, lv, m_busy, (mq.size() != DEPTH) && !flush};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_load   = 1'b0;
    m_load_h = 4'h0;
    m_busy   = 1'b0;
    arm_at   = -1;
    free_at  = cyc + 1;
  endtask

  // One clock edge: advance the model with the inputs present before the edge.
  task automatic tick();
    logic       ready_exp;
    logic [4:0] hd;
    bit         popped;
    ready_exp = (mq.size() != DEPTH) && !flush;
    @(posedge clk);
    cyc++;
    popped = 0;
    hd     = 5'h0;
    m_load = 1'b0;
    if (flush) begin
      mq.delete();
      arm_at  = -1;
      free_at = cyc + 1;
    end else begin
      if (mq.size() > 0 && cyc >= free_at) begin
        hd = mq[0];
`ifdef COUNTER_LOAD_SEQ_SYNC_EN
        if (!hd[4])                 popped = 1;
        else if (arm_at < 0)        arm_at = cyc;
        else if (count_in == 4'hF)  popped = 1;
`else
        popped = 1;
`endif
      end
      if (popped) begin
        void'(mq.pop_front());
        m_load   = 1'b1;
        m_load_h = hd[3:0];
        free_at  = cyc + 3;
        arm_at   = -1;
      end
      if (req_valid && ready_exp) mq.push_back({req_sync, req_data});
    end
    m_busy = (mq.size() > 0) || (cyc < free_at - 1);
    #1;
  endtask

  // Bring the design to an idle, empty state without checking anything.
  task automatic quiesce();
    req_valid = 1'b0; count_in = 4'h0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (got !== 10'b0000000001) $display("FAIL reset_async got=%b exp=%b", got, 10'b0000000001);
    else passes++;
    #1 rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (got !== expv()) $display("FAIL reset_idle got=%b exp=%b", got, expv());
    else passes++;
  endtask

  task automatic test_two_immediate();
    int first = -1, second = -1, npulse = 0;
    logic [3:0] h1 = 4'h0, h2 = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      req_sync  = 1'b0;
      req_valid = (k <= 2);
      req_data  = (k == 1) ? 4'h3 : 4'h9;
      tick();
      checks++;
      if (got !== expv()) $display("FAIL imm_model k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
      if (load === 1'b1) begin
        npulse++;
        if (first < 0) begin first = k; h1 = load_h; end
        else begin second = k; h2 = load_h; end
      end
    end
    checks++;
    if (npulse != 2 || first != 2 || second != 5)
      $display("FAIL imm_timing pulses=%0d at %0d,%0d exp 2 at 2,5", npulse, first, second);
    else passes++;
    checks++;
    if (h1 !== 4'h3 || h2 !== 4'h9 || load_h !== 4'h9)
      $display("FAIL imm_values load_h=%h,%h final=%h exp 3,9 final=9", h1, h2, load_h);
    else passes++;
  endtask

  task automatic test_sync();
    int first = -1, npulse = 0;
    logic [3:0] h1 = 4'h0;
    quiesce();
    for (int k = 1; k <= 8; k++) begin
      req_valid = (k == 1); req_sync = 1'b1; req_data = 4'h5;
      case (k)
        2: count_in = 4'hC;
        3: count_in = 4'hD;
        4: count_in = 4'hE;
        5: count_in = 4'hF;
        default: count_in = 4'h0;
      endcase
      tick();
      checks++;
      if (got !== expv()) $display("FAIL sync_model k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
      if (load === 1'b1) begin npulse++; if (first < 0) begin first = k; h1 = load_h; end end
    end
    checks++;
    if (npulse != 1 || first != SYNC_PULSE || h1 !== 4'h5)
      $display("FAIL sync_ramp pulses=%0d at %0d val=%h exp 1 at %0d val=5", npulse, first, h1, SYNC_PULSE);
    else passes++;
    // Count already at wrap when the entry arrives
    first = -1;
    count_in = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      req_valid = (k == 1); req_sync = 1'b1; req_data = 4'hA;
      tick();
      checks++;
      if (got !== expv()) $display("FAIL syncf_model k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
      if (load === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != SYNC_F_PULSE) $display("FAIL sync_at_wrap pulse at %0d exp %0d", first, SYNC_F_PULSE);
    else passes++;
    count_in = 4'h0;
  endtask

  task automatic test_full();
    int idx = 0;
    bit acc;
    quiesce();
    for (int k = 1; k <= 14; k++) begin
      req_valid = (idx < 5); req_sync = 1'b1; req_data = 4'(idx + 1);
      count_in  = (k >= 8) ? 4'hF : 4'h0;
      acc = req_valid && req_ready;
      tick();
      checks++;
      if (got !== expv()) $display("FAIL full_model k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
      if (acc) idx++;
`ifdef COUNTER_LOAD_SEQ_SYNC_EN
      if (k == 4) begin
        checks++;
        if (level !== 3'd4 || req_ready !== 1'b0)
          $display("FAIL full_sat level=%0d rdy=%b exp 4,0", level, req_ready);
        else passes++;
      end
      if (k == 8) begin
        checks++;
        if (idx != 4 || level !== 3'd3)
          $display("FAIL full_no_push_on_pop accepted=%0d level=%0d exp 4,3", idx, level);
        else passes++;
      end
      if (k == 9) begin
        checks++;
        if (idx != 5 || level !== 3'd4)
          $display("FAIL full_fifth accepted=%0d level=%0d exp 5,4", idx, level);
        else passes++;
      end
`endif
    end
    count_in = 4'h0;
  endtask

  task automatic test_flush();
    logic [3:0] h_exp;
    int npulse = 0;
    quiesce();
    for (int k = 1; k <= 4; k++) begin
      req_valid = (k <= 3); req_sync = 1'b1; req_data = 4'(k + 6); count_in = 4'h0;
      tick();
      checks++;
      if (got !== expv()) $display("FAIL flush_fill k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
    end
    h_exp = m_load_h;
    flush = 1'b1; req_valid = 1'b1; count_in = 4'hF;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    checks++;
    if (level !== 3'd0 || busy !== 1'b0 || load !== 1'b0 || load_h !== h_exp)
      $display("FAIL flush_edge level=%0d busy=%b load=%b load_h=%h exp 0,0,0,%h",
               level, busy, load, load_h, h_exp);
    else passes++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (got !== expv()) $display("FAIL flush_after k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
      if (load === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 0) $display("FAIL flush_no_pulse pulses=%0d exp 0", npulse);
    else passes++;
    count_in = 4'h0;
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    quiesce();
    for (int k = 1; k <= 5; k++) begin
      req_valid = (k <= 4); req_sync = 1'b0; req_data = 4'(k + 10);
      tick();
      checks++;
      if (got !== expv()) $display("FAIL rstmid_fill k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
    end
    checks++;
    if (load !== 1'b1 || level !== 3'd2) $display("FAIL rstmid_setup load=%b level=%0d exp 1,2", load, level);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got !== 10'b0000000001) $display("FAIL rstmid_async got=%b exp=%b", got, 10'b0000000001);
    else passes++;
    #2 rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (got !== expv()) $display("FAIL rstmid_after k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
      if (load === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 0) $display("FAIL rstmid_no_pulse pulses=%0d exp 0", npulse);
    else passes++;
  endtask

  task automatic test_random();
    quiesce();
    for (int k = 0; k < 600; k++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_data  = 4'($urandom_range(0, 15));
      req_sync  = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 29) == 0);
      count_in  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (got !== expv()) $display("FAIL random k=%0d got=%b exp=%b", k, got, expv());
      else passes++;
    end
    flush = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_immediate();
    test_sync();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
